// File: rtl/gray_conv_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// gray_conv_arbiter_pkg
// Shared definitions for the Gray-to-binary conversion arbiter:
//   - default WIDTH / CNT_W values
//   - output-stage FSM state encoding (EMPTY / FULL)
//   - requester id constants
// -----------------------------------------------------------------------------
package gray_conv_arbiter_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

  // Output stage: EMPTY means no result held, FULL means out_valid is high
  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/gray_conv_arbiter_if.sv
// -----------------------------------------------------------------------------
// gray_conv_arbiter_if
// Bundles the two requester channels, the result channel and the transfer
// counter of gray_conv_arbiter.
//   req0_valid/req0_gray/req0_ready : requester 0 handshake
//   req1_valid/req1_gray/req1_ready : requester 1 handshake
//   out_valid/out_bin/out_id/out_ready : result handshake
//   conv_count : completed result transfers (saturating)
// Modports: master = requesters + consumer side, slave = the arbiter.
// -----------------------------------------------------------------------------
interface gray_conv_arbiter_if
  import gray_conv_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             req0_valid;
  logic [WIDTH-1:0] req0_gray;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_gray;
  logic             req1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_bin;
  logic             out_id;
  logic             out_ready;
  logic [CNT_W-1:0] conv_count;

  modport master (
    output req0_valid, req0_gray, req1_valid, req1_gray, out_ready,
    input  req0_ready, req1_ready, out_valid, out_bin, out_id, conv_count
  );

  modport slave (
    input  req0_valid, req0_gray, req1_valid, req1_gray, out_ready,
    output req0_ready, req1_ready, out_valid, out_bin, out_id, conv_count
  );

endinterface

// File: rtl/gray_conv_arbiter_gray2bin_n.sv
// -----------------------------------------------------------------------------
// gray2bin_n
// Purely combinational Gray-to-binary converter.
//   i_gray : WIDTH-bit Gray code
//   o_bin  : WIDTH-bit binary equivalent
// Binary bit i is the XOR of all Gray bits from the MSB down to bit i, which
// is the unrolled form of B[i] = B[i+1] ^ G[i] with B[MSB] = G[MSB].
// -----------------------------------------------------------------------------
module gray2bin_n
  import gray_conv_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    // Shifting drops bits below gi, so the reduction covers G[MSB..gi]
    assign o_bin[gi] = ^(i_gray >> gi);
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// -----------------------------------------------------------------------------
// gray_conv_arbiter
// Two requesters offer Gray words; a round-robin arbiter grants one per cycle
// into a single-entry output register holding the binary equivalent.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (release synchronized externally)
//   bus   : gray_conv_arbiter_if.slave (request, result and counter signals)
// Readys are combinational from grant and slot state; all result outputs and
// conv_count come straight from registers.
// -----------------------------------------------------------------------------
module gray_conv_arbiter
  import gray_conv_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gray_conv_arbiter_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           r_state;
  logic [WIDTH-1:0] r_out_bin;
  logic             r_out_id;
  logic             r_last_id;   // id of the most recent accept; reset to 1 so req0 wins the first tie
  logic [CNT_W-1:0] r_conv_count;

  logic             w_slot_free;
  logic             w_gnt_vld;
  logic             w_gnt_id;
  logic             w_accept;
  logic             w_xfer;
  logic [WIDTH-1:0] w_gnt_gray;
  logic [WIDTH-1:0] w_bin;

  // Slot can take a new word when empty or when the held word leaves this cycle
  assign w_slot_free = (r_state == EMPTY) || bus.out_ready;
  assign w_accept    = w_slot_free && w_gnt_vld;
  assign w_xfer      = (r_state == FULL) && bus.out_ready;

  // Grant selection: a lone requester wins, a tie goes to the one not granted last
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = ID_REQ0;
    case ({bus.req1_valid, bus.req0_valid})
      2'b01: begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = ID_REQ0;
      end
      2'b10: begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = ID_REQ1;
      end
      2'b11: begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = ~r_last_id;
      end
      default: begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = ID_REQ0;
      end
    endcase
  end

  assign bus.req0_ready = w_slot_free && w_gnt_vld && (w_gnt_id == ID_REQ0);
  assign bus.req1_ready = w_slot_free && w_gnt_vld && (w_gnt_id == ID_REQ1);

  assign w_gnt_gray = (w_gnt_id == ID_REQ1) ? bus.req1_gray : bus.req0_gray;

  gray2bin_n #(
    .WIDTH (WIDTH)
  ) u_gray2bin (
    .i_gray (w_gnt_gray),
    .o_bin  (w_bin)
  );

  // Output stage FSM, result register and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= EMPTY;
      r_out_bin <= {WIDTH{1'b0}};
      r_out_id  <= ID_REQ0;
      r_last_id <= ID_REQ1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_state   <= FULL;
            r_out_bin <= w_bin;
            r_out_id  <= w_gnt_id;
            r_last_id <= w_gnt_id;
          end else begin
            r_state   <= EMPTY;
          end
        end
        FULL: begin
          if (w_accept) begin
            // Back-to-back: consumer takes the old word while the new one loads
            r_state   <= FULL;
            r_out_bin <= w_bin;
            r_out_id  <= w_gnt_id;
            r_last_id <= w_gnt_id;
          end else if (bus.out_ready) begin
            // Drained with nothing new; data registers keep the last value
            r_state   <= EMPTY;
          end else begin
            r_state   <= FULL;
          end
        end
        default: begin
          r_state   <= EMPTY;
        end
      endcase
    end
  end

  // Completed-transfer counter, saturating at all ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conv_count <= {CNT_W{1'b0}};
    end else if (w_xfer && (r_conv_count != CNT_MAX)) begin
      r_conv_count <= r_conv_count + CNT_ONE;
    end else begin
      r_conv_count <= r_conv_count;
    end
  end

  assign bus.out_valid  = (r_state == FULL);
  assign bus.out_bin    = r_out_bin;
  assign bus.out_id     = r_out_id;
  assign bus.conv_count = r_conv_count;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gray_conv_arbiter
// Drives two instances (CNT_W=8 and CNT_W=2) with identical stimulus and
// compares against a transaction-level reference model. Gray decoding in the
// model uses a lookup table built by encoding every binary value.
// -----------------------------------------------------------------------------
module tb_gray_conv_arbiter;

  logic clk;
  logic rst_n;

  logic       tb_v0, tb_v1, tb_ordy;
  logic [3:0] tb_g0, tb_g1;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit       m_full;
  bit [3:0] m_bin;
  bit       m_id;
  bit       m_last;
  int       m_cnt;
  int       m_cnt2;
  bit [3:0] tbl [16];

  gray_conv_arbiter_if #(.WIDTH(4), .CNT_W(8)) bus_a ();
  gray_conv_arbiter_if #(.WIDTH(4), .CNT_W(2)) bus_b ();

  assign bus_a.req0_valid = tb_v0;
  assign bus_a.req0_gray  = tb_g0;
  assign bus_a.req1_valid = tb_v1;
  assign bus_a.req1_gray  = tb_g1;
  assign bus_a.out_ready  = tb_ordy;
  assign bus_b.req0_valid = tb_v0;
  assign bus_b.req0_gray  = tb_g0;
  assign bus_b.req1_valid = tb_v1;
  assign bus_b.req1_gray  = tb_g1;
  assign bus_b.out_ready  = tb_ordy;

  gray_conv_arbiter #(.WIDTH(4), .CNT_W(8)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  gray_conv_arbiter #(.WIDTH(4), .CNT_W(2)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_full = 1'b0;
    m_bin  = 4'd0;
    m_id   = 1'b0;
    m_last = 1'b1;
    m_cnt  = 0;
    m_cnt2 = 0;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_valid"}, bus_a.out_valid, m_full);
    check_eq({tag, "_bin"},   bus_a.out_bin,   m_bin);
    check_eq({tag, "_id"},    bus_a.out_id,    m_id);
    check_eq({tag, "_cnt"},   bus_a.conv_count, m_cnt);
    check_eq({tag, "_validb"}, bus_b.out_valid, m_full);
    check_eq({tag, "_cntb"},  bus_b.conv_count, m_cnt2);
  endtask

  // One clock cycle: apply inputs, check readys, advance model, check outputs
  task automatic drive(input logic v0, input logic [3:0] g0, input logic v1,
                       input logic [3:0] g1, input logic ordy, input string tag);
    bit slot, e_r0, e_r1;
    @(negedge clk);
    tb_v0 = v0; tb_g0 = g0; tb_v1 = v1; tb_g1 = g1; tb_ordy = ordy;
    #1;
    slot = !m_full || ordy;
    e_r0 = slot && v0 && (!v1 || m_last);
    e_r1 = slot && v1 && (!v0 || !m_last);
    check_eq({tag, "_rdy0"}, bus_a.req0_ready, e_r0);
    check_eq({tag, "_rdy1"}, bus_a.req1_ready, e_r1);
    check_eq({tag, "_rdy0b"}, bus_b.req0_ready, e_r0);
    check_eq({tag, "_rdy1b"}, bus_b.req1_ready, e_r1);
    @(posedge clk);
    if (rst_n) begin
      if (m_full && ordy) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (e_r0 || e_r1) begin
        m_full = 1'b1;
        m_id   = e_r1;
        m_last = e_r1;
        m_bin  = e_r1 ? tbl[g1] : tbl[g0];
      end else if (ordy) begin
        m_full = 1'b0;
      end
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    int exp37 [5];
    bit [3:0] gc;
    exp37 = '{1, 2, 3, 3, 3};
    for (int b = 0; b < 16; b++) begin
      gc = 4'(b ^ (b >> 1));
      tbl[gc] = 4'(b);
    end

    rst_n = 1'b0;
    tb_v0 = 1'b0; tb_v1 = 1'b0; tb_g0 = 4'd0; tb_g1 = 4'd0; tb_ordy = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // single requester, first word after reset, then counter progression
    drive(1'b1, 4'b1000, 1'b0, 4'd0, 1'b1, "first");
    check_eq("first_bin_const", bus_a.out_bin, 4'b1111);
    check_eq("first_id_const",  bus_a.out_id,  1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 4'b1000, 1'b0, 4'd0, 1'b1, "cnt");
      check_eq("cnt2_seq", bus_b.conv_count, exp37[k]);
    end

    // both requesters continuously: ids must alternate every cycle
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 4'b0110, 1'b1, 4'b1101, 1'b1, "rr");
      check_eq("rr_bin_const", bus_a.out_bin, m_id ? 4'b1001 : 4'b0100);
    end

    // stall: consumer not ready for 5 cycles with inputs changing
    for (int k = 0; k < 5; k++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b0, "stall");
    end

    // every Gray code through requester 1
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 4'd0, 1'b1, 4'(k), 1'b1, "all16");
    end

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 3) != 0), "rand");
    end

    // reset while holding a result: must clear without a clock edge
    drive(1'b1, 4'b0101, 1'b0, 4'd0, 1'b0, "prerst");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    drive(1'b1, 4'b0011, 1'b1, 4'b0111, 1'b1, "inrst");
    rst_n = 1'b1;
    drive(1'b1, 4'b0011, 1'b1, 4'b0111, 1'b1, "postrst");
    check_eq("postrst_id_const", bus_a.out_id, 1'b0);
    for (int k = 0; k < 20; k++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), "tail");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_conv_arbiter.md
GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the bit width of Gray inputs and binary output.
REQ-002 Parameter CNT_W, default 8, SHALL set the width of the conversion counter.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 req0_valid  input  1  SHALL mean requester 0 presents a Gray word.
REQ-006 req0_gray  input  WIDTH  SHALL be requester 0's Gray word.
REQ-007 req0_ready  output  1  SHALL mean requester 0's word is accepted this cycle.
REQ-008 req1_valid, req1_gray, req1_ready SHALL mirror REQ-005..007 for requester 1.
REQ-009 out_valid  output  1  SHALL mean out_bin/out_id hold a valid result.
REQ-010 out_bin  output  WIDTH  SHALL be the binary equivalent of the accepted Gray word.
REQ-011 out_id  output  1  SHALL identify the requester (0/1) whose word produced out_bin.
REQ-012 out_ready  input  1  SHALL mean the consumer takes the result this cycle.
REQ-013 conv_count  output  CNT_W  SHALL count completed output transfers.

Function
REQ-014 Conversion SHALL be B[WIDTH-1]=G[WIDTH-1], B[i]=B[i+1]^G[i] for i<WIDTH-1; e.g. 4'b1000->4'b1111, 4'b0110->4'b0100.
REQ-015 Output stage SHALL be a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 Slot-free condition SHALL be (state==EMPTY) or (out_ready==1).
REQ-017 When slot free and exactly one reqN_valid is high, that requester SHALL be granted.
REQ-018 When slot free and both valid, grant SHALL go to the requester not granted last (round-robin pointer).
REQ-019 reqN_ready SHALL be high only for the granted requester and only while slot free; combinational, no dependence on reqN_valid of the same requester beyond grant.
REQ-020 An accept (reqN_valid&reqN_ready) at edge t SHALL load out_bin, out_id and set FULL, visible at t+1: latency 1 cycle.
REQ-021 In FULL with out_ready=0, out_bin/out_id/out_valid SHALL hold stable, both readys low.
REQ-022 In FULL with out_ready=1 and a new accept, FSM SHALL stay FULL with new data: sustained throughput 1 word/cycle.
REQ-023 In FULL with out_ready=1 and no accept, FSM SHALL go EMPTY; out_bin/out_id hold last value.
REQ-024 Round-robin pointer SHALL update only on accept, to the id accepted.
REQ-025 conv_count SHALL increment on each out_valid&out_ready, saturating at 2^CNT_W-1.
REQ-026 Input changes while reqN_ready=0 SHALL have no effect on state.

Reset
REQ-027 While rst_n=0: state EMPTY, out_valid=0, out_bin=0, out_id=0, conv_count=0, pointer so requester 0 wins first tie.
REQ-028 Reset assertion mid-transfer SHALL discard the held result immediately; no transfer completes during reset.
REQ-029 Release SHALL be synchronized externally; first accept possible on the first edge with rst_n=1.

Structure
REQ-030 Shared package SHALL hold FSM state enum (EMPTY, FULL) and default WIDTH/CNT_W constants.
REQ-031 Conversion SHALL be a separate combinational sub-module gray2bin_n (WIDTH-parameterized), instantiated once, fed by a grant mux.

Verification
REQ-032 After reset, req0_valid=1, req0_gray=4'b1000, out_ready=1 -> next cycle out_valid=1, out_bin=4'b1111, out_id=0, conv_count=1 one cycle later.
REQ-033 Both valid continuously (req0=4'b0110, req1=4'b1101), out_ready=1 -> outputs alternate id 0 (4'b0100), id 1 (4'b1001), 0, 1 ... every cycle.
REQ-034 FULL with out_ready=0 for 5 cycles -> out_bin/out_id constant, req0_ready=req1_ready=0, conv_count unchanged.
REQ-035 All 16 Gray codes via req1 -> out_bin matches REQ-014 table (e.g. 4'b1111->4'b1010).
REQ-036 rst_n low while FULL -> out_valid=0, out_bin=0, conv_count=0 immediately, without waiting for clk.
REQ-037 CNT_W=2, 5 transfers -> conv_count reads 1,2,3,3,3.
